// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch front end.
// Issues sequential fetch requests from a fetch PC, tracks outstanding
// requests in a small circular fetch queue, fills entries with responses in
// request order and presents the oldest filled entry to decode. A redirect
// flushes the queue and remembers how many in-flight responses still belong
// to the flushed path so they can be discarded when they arrive.
//
// Handshake rule for every valid/ready pair on this block: a transfer
// happens on a rising clk edge exactly when valid and ready are both high in
// the cycle before that edge; valid may drop without a transfer, and neither
// side may make valid depend on ready of the same pair.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              FQ_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic                          imem_req_valid,
    input  logic                          imem_req_ready,
    output logic [XLEN-1:0]               imem_req_addr,
    input  logic                          imem_rsp_valid,
    input  logic [31:0]                   imem_rsp_data,
    input  logic                          redirect,
    input  logic [XLEN-1:0]               redirect_pc,
    output logic                          id_valid,
    input  logic                          id_ready,
    output logic [31:0]                   id_instr,
    output logic [XLEN-1:0]               id_pc,
    output logic [XLEN-1:0]               id_pc4,
    output logic [$clog2(FQ_DEPTH+1)-1:0] fq_count
);

    localparam int PTR_W = $clog2(FQ_DEPTH);
    localparam int CNT_W = $clog2(FQ_DEPTH + 1);
    // Flushed responses can pile up across back-to-back redirects while the
    // memory still holds them, so the drop counter gets headroom beyond one
    // queue's worth of entries.
    localparam int DROP_W = CNT_W + 4;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FQ_DEPTH);

    // Queue storage: address and instruction per entry plus a filled flag.
    logic [XLEN-1:0]   pc_mem_q    [FQ_DEPTH];
    logic [31:0]       instr_mem_q [FQ_DEPTH];
    logic [FQ_DEPTH-1:0] filled_q, filled_d;

    // head: oldest entry, tail: next free slot, fill: oldest unfilled entry.
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [PTR_W-1:0]  fill_q, fill_d;

    // count: allocated entries, pend: allocated but not yet filled.
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  pend_q, pend_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [XLEN-1:0]   pc_q, pc_d;

    logic q_empty;
    logic req_fire;
    logic rsp_drop;
    logic rsp_fill;
    logic pop;

    assign q_empty  = (count_q == '0);
    assign req_fire = imem_req_valid && imem_req_ready;
    // A response first pays off outstanding drops; only then may it fill.
    assign rsp_drop = imem_rsp_valid && (drop_q != '0);
    assign rsp_fill = imem_rsp_valid && (drop_q == '0) && (pend_q != '0);
    assign pop      = id_valid && id_ready;

    // Request side: held low in reset, during a redirect and when full.
    assign imem_req_valid = rst_n && !redirect && (count_q < DEPTH_C);
    assign imem_req_addr  = pc_q;

    // Decode side: head entry, forced to zero when nothing is allocated.
    assign id_valid = !q_empty && filled_q[head_q] && !redirect;
    assign id_instr = q_empty ? '0 : instr_mem_q[head_q];
    assign id_pc    = q_empty ? '0 : pc_mem_q[head_q];
    assign id_pc4   = q_empty ? '0 : pc_mem_q[head_q] + XLEN'(4);
    assign fq_count = count_q;

    // Next-state for pointers, counters, filled flags and fetch PC.
    always_comb begin
        pc_d     = pc_q;
        head_d   = head_q;
        tail_d   = tail_q;
        fill_d   = fill_q;
        count_d  = count_q;
        pend_d   = pend_q;
        drop_d   = drop_q;
        filled_d = filled_q;
        if (redirect) begin
            // Flush everything; every still-unfilled entry becomes a drop.
            // A response arriving this cycle has already been charged to
            // either the old drop count or one of the unfilled entries.
            pc_d     = redirect_pc;
            head_d   = '0;
            tail_d   = '0;
            fill_d   = '0;
            count_d  = '0;
            pend_d   = '0;
            filled_d = '0;
            drop_d   = drop_q - DROP_W'(rsp_drop) + DROP_W'(pend_q)
                       - DROP_W'(rsp_fill);
        end else begin
            drop_d = drop_q - DROP_W'(rsp_drop);
            if (req_fire) begin
                tail_d           = tail_q + PTR_W'(1);
                pc_d             = pc_q + XLEN'(4);
                filled_d[tail_q] = 1'b0;
            end
            if (rsp_fill) begin
                fill_d           = fill_q + PTR_W'(1);
                filled_d[fill_q] = 1'b1;
            end
            if (pop) begin
                head_d           = head_q + PTR_W'(1);
                filled_d[head_q] = 1'b0;
            end
            count_d = count_q + CNT_W'(req_fire) - CNT_W'(pop);
            pend_d  = pend_q + CNT_W'(req_fire) - CNT_W'(rsp_fill);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            head_q   <= '0;
            tail_q   <= '0;
            fill_q   <= '0;
            count_q  <= '0;
            pend_q   <= '0;
            drop_q   <= '0;
            filled_q <= '0;
        end else begin
            pc_q     <= pc_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            fill_q   <= fill_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
            drop_q   <= drop_d;
            filled_q <= filled_d;
        end
    end

    // Entry payload: address written on allocation, instruction on fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FQ_DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else begin
            if (req_fire) begin
                pc_mem_q[tail_q] <= pc_q;
            end
            if (rsp_fill && !redirect) begin
                instr_mem_q[fill_q] <= imem_rsp_data;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed bench for fetch_unit.
// A queue-level model (entries in program order, a drop budget, an in-order
// memory of outstanding addresses) predicts every output each cycle; popped
// instructions are also checked for program order and for carrying the
// memory word of their own address.
module tb_fetch_unit;

    localparam int          XLEN = 32;
    localparam int          D    = 4;
    localparam logic [31:0] RPC  = 32'h0000_0000;
    localparam int          MEM_MAX_OUT = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [2:0]  fq_count;

    fetch_unit #(
        .XLEN(XLEN),
        .RESET_PC(RPC),
        .FQ_DEPTH(D)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .id_valid(id_valid),
        .id_ready(id_ready),
        .id_instr(id_instr),
        .id_pc(id_pc),
        .id_pc4(id_pc4),
        .fq_count(fq_count)
    );

    // ---------------- model state ----------------
    typedef struct {
        logic [31:0] pc;
        logic        filled;
        logic [31:0] instr;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pc;
    int          m_drop;
    logic [31:0] mem_q[$];
    logic [31:0] next_pop_pc;

    logic [31:0] fire_addr[$];
    int          fire_cyc[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_pc4[$];
    int          pop_cyc[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic int unfilled();
        int n = 0;
        foreach (m_q[i]) if (!m_q[i].filled) n++;
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        fire_addr.delete();
        fire_cyc.delete();
        pop_pc.delete();
        pop_pc4.delete();
        pop_cyc.delete();
    endtask

    // ---------------- driver ----------------
    task automatic drive(input bit rdy, input bit rsp_en, input bit idr,
                         input bit redir, input logic [31:0] rpc);
        imem_req_ready = rdy && (mem_q.size() < MEM_MAX_OUT);
        id_ready       = idr;
        redirect       = redir;
        redirect_pc    = rpc;
        if (rsp_en && mem_q.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_data(mem_q[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    endtask

    // ---------------- compare + model step (one cycle) ----------------
    task automatic tick();
        logic        exp_rv, exp_idv, fire, pop, rsp, redir, done;
        logic [31:0] rdata, rpc;
        #2;
        exp_rv  = !redirect && (m_q.size() < D);
        exp_idv = (m_q.size() > 0) && m_q[0].filled && !redirect;
        check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        check("req_addr", imem_req_addr, m_pc);
        check("id_valid", 32'(id_valid), 32'(exp_idv));
        check("fq_count", 32'(fq_count), m_q.size());
        if (m_q.size() == 0) begin
            check("id_pc_empty", id_pc, 32'h0);
            check("id_pc4_empty", id_pc4, 32'h0);
            check("id_instr_empty", id_instr, 32'h0);
        end else begin
            check("id_pc", id_pc, m_q[0].pc);
            check("id_pc4", id_pc4, m_q[0].pc + 32'd4);
            if (exp_idv) check("id_instr", id_instr, m_q[0].instr);
        end
        fire = exp_rv && imem_req_ready;
        pop  = exp_idv && id_ready;
        if (fire) begin
            fire_addr.push_back(imem_req_addr);
            fire_cyc.push_back(cyc);
        end
        if (pop) begin
            pop_pc.push_back(id_pc);
            pop_pc4.push_back(id_pc4);
            pop_cyc.push_back(cyc);
            check("pop_order", id_pc, next_pop_pc);
            check("pop_instr", id_instr, mem_data(id_pc));
            next_pop_pc = next_pop_pc + 32'd4;
        end
        rsp   = imem_rsp_valid;
        rdata = imem_rsp_data;
        redir = redirect;
        rpc   = redirect_pc;

        @(posedge clk);
        cyc++;
        #1;

        if (rsp) begin
            void'(mem_q.pop_front());
            if (m_drop > 0) begin
                m_drop--;
            end else begin
                done = 1'b0;
                foreach (m_q[i]) begin
                    if (!done && !m_q[i].filled) begin
                        m_q[i].filled = 1'b1;
                        m_q[i].instr  = rdata;
                        done = 1'b1;
                    end
                end
            end
        end
        if (redir) begin
            m_drop      = m_drop + unfilled();
            m_q.delete();
            m_pc        = rpc;
            next_pop_pc = rpc;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (fire) begin
                ent_t e;
                e.pc     = m_pc;
                e.filled = 1'b0;
                e.instr  = '0;
                m_q.push_back(e);
                mem_q.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // ---------------- reset pulse (asserted between edges) ----------------
    task automatic do_reset(input bit keep_one);
        logic [31:0] s;
        redirect       = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        id_ready       = 1'b0;
        rst_n          = 1'b0;
        #1;
        check("rst_id_valid", 32'(id_valid), 32'h0);
        check("rst_req_valid", 32'(imem_req_valid), 32'h0);
        check("rst_fq_count", 32'(fq_count), 32'h0);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_id_pc4", id_pc4, 32'h0);
        check("rst_id_instr", id_instr, 32'h0);
        m_q.delete();
        m_drop      = 0;
        m_pc        = RPC;
        next_pop_pc = RPC;
        if (keep_one && mem_q.size() > 0) begin
            s = mem_q[0];
            mem_q.delete();
            mem_q.push_back(s);
        end else begin
            mem_q.delete();
        end
        @(posedge clk);
        cyc++;
        #1;
        check("rst_req_addr", imem_req_addr, RPC);
        check("rst_req_valid_hold", 32'(imem_req_valid), 32'h0);
        rst_n = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int r;
        int p_ready, p_rsp, p_idr, p_red;
        logic [31:0] rpc;

        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect       = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b0;
        m_pc           = RPC;
        m_drop         = 0;
        next_pop_pc    = RPC;

        repeat (2) @(posedge clk);
        #1;
        check("init_id_valid", 32'(id_valid), 32'h0);
        check("init_req_valid", 32'(imem_req_valid), 32'h0);
        check("init_fq_count", 32'(fq_count), 32'h0);
        check("init_req_addr", imem_req_addr, RPC);
        check("init_id_pc", id_pc, 32'h0);
        check("init_id_pc4", id_pc4, 32'h0);
        check("init_id_instr", id_instr, 32'h0);
        rst_n = 1'b1;

        // Streaming from reset: 1-cycle memory, decode always ready.
        clear_logs();
        repeat (8) begin drive(1, 1, 1, 0, 0); tick(); end
        check("t1_fire0", fire_addr.size() > 0 ? fire_addr[0] : 32'hDEAD_BEEF, 32'h0);
        check("t1_fire1", fire_addr.size() > 1 ? fire_addr[1] : 32'hDEAD_BEEF, 32'h4);
        check("t1_fire2", fire_addr.size() > 2 ? fire_addr[2] : 32'hDEAD_BEEF, 32'h8);
        check("t1_fire_gap", fire_cyc.size() > 2 ? 32'(fire_cyc[2] - fire_cyc[0]) : 32'hDEAD_BEEF, 32'd2);
        check("t1_pop0", pop_pc.size() > 0 ? pop_pc[0] : 32'hDEAD_BEEF, 32'h0);
        check("t1_pop1", pop_pc.size() > 1 ? pop_pc[1] : 32'hDEAD_BEEF, 32'h4);
        check("t1_pop2", pop_pc.size() > 2 ? pop_pc[2] : 32'hDEAD_BEEF, 32'h8);
        check("t1_pc4_0", pop_pc4.size() > 0 ? pop_pc4[0] : 32'hDEAD_BEEF, 32'h4);
        check("t1_pc4_1", pop_pc4.size() > 1 ? pop_pc4[1] : 32'hDEAD_BEEF, 32'h8);
        check("t1_pc4_2", pop_pc4.size() > 2 ? pop_pc4[2] : 32'hDEAD_BEEF, 32'hC);
        check("t1_pop_gap", pop_cyc.size() > 2 ? 32'(pop_cyc[2] - pop_cyc[0]) : 32'hDEAD_BEEF, 32'd2);
        check("t1_latency", (pop_cyc.size() > 0 && fire_cyc.size() > 0) ?
              32'(pop_cyc[0] - fire_cyc[0]) : 32'hDEAD_BEEF, 32'd2);

        // Decode stall for 10 cycles: queue saturates, requests stop.
        repeat (10) begin drive(1, 1, 0, 0, 0); tick(); end
        drive(1, 1, 0, 0, 0);
        #1;
        check("t2_full_count", 32'(fq_count), 32'd4);
        check("t2_full_req_valid", 32'(imem_req_valid), 32'h0);
        tick();
        repeat (12) begin drive(1, 1, 1, 0, 0); tick(); end

        // Redirect with two requests outstanding.
        do_reset(0);
        clear_logs();
        drive(1, 0, 1, 1, 32'h10); tick();
        drive(1, 0, 1, 0, 0); tick();
        drive(1, 0, 1, 0, 0); tick();
        r = cyc;
        drive(0, 0, 1, 1, 32'h100); tick();
        check("t3_flush_count", 32'(fq_count), 32'h0);
        repeat (8) begin drive(1, 1, 1, 0, 0); tick(); end
        check("t3_first_pop", pop_pc.size() > 0 ? pop_pc[0] : 32'hDEAD_BEEF, 32'h100);
        check("t3_pop_cycle", pop_cyc.size() > 0 ? 32'(pop_cyc[0] - r) : 32'hDEAD_BEEF, 32'd4);

        // Redirect coinciding with the response for 0x10, 0x14 outstanding.
        do_reset(0);
        clear_logs();
        drive(1, 0, 1, 1, 32'h10); tick();
        drive(1, 0, 1, 0, 0); tick();
        drive(1, 0, 1, 0, 0); tick();
        r = cyc;
        drive(0, 1, 1, 1, 32'h200); tick();
        repeat (8) begin drive(1, 1, 1, 0, 0); tick(); end
        check("t4_first_pop", pop_pc.size() > 0 ? pop_pc[0] : 32'hDEAD_BEEF, 32'h200);
        check("t4_pop_cycle", pop_cyc.size() > 0 ? 32'(pop_cyc[0] - r) : 32'hDEAD_BEEF, 32'd3);

        // Address wrap at the top of the address space.
        do_reset(0);
        clear_logs();
        drive(1, 0, 1, 1, 32'hFFFF_FFFC); tick();
        repeat (6) begin drive(1, 1, 1, 0, 0); tick(); end
        check("t5_fire0", fire_addr.size() > 0 ? fire_addr[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        check("t5_fire1", fire_addr.size() > 1 ? fire_addr[1] : 32'hDEAD_BEEF, 32'h0);
        check("t5_pop0", pop_pc.size() > 0 ? pop_pc[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        check("t5_pc4_0", pop_pc4.size() > 0 ? pop_pc4[0] : 32'hDEAD_BEEF, 32'h0);

        // Reset with three entries filled and one response still pending.
        do_reset(0);
        clear_logs();
        drive(1, 0, 0, 1, 32'h40); tick();
        repeat (4) begin drive(1, 1, 0, 0, 0); tick(); end
        check("t6_count", 32'(fq_count), 32'd4);
        check("t6_id_valid", 32'(id_valid), 32'h1);
        do_reset(1);
        clear_logs();
        repeat (6) begin drive(1, 1, 1, 0, 0); tick(); end
        check("t6_first_req", fire_addr.size() > 0 ? fire_addr[0] : 32'hDEAD_BEEF, RPC);
        check("t6_first_pop", pop_pc.size() > 0 ? pop_pc[0] : 32'hDEAD_BEEF, RPC);
        check("t6_latency", (pop_cyc.size() > 0 && fire_cyc.size() > 0) ?
              32'(pop_cyc[0] - fire_cyc[0]) : 32'hDEAD_BEEF, 32'd2);

        // Randomized traffic in blocks with varying pressure.
        do_reset(0);
        for (int blk = 0; blk < 15; blk++) begin
            p_ready = $urandom_range(30, 100);
            p_rsp   = $urandom_range(20, 100);
            p_idr   = $urandom_range(20, 100);
            p_red   = $urandom_range(0, 8);
            for (int k = 0; k < 200; k++) begin
                if ($urandom_range(0, 999) == 0) do_reset(0);
                rpc = $urandom;
                rpc[1:0] = 2'b00;
                if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 + {28'h0, rpc[3:2], 2'b00};
                drive($urandom_range(0, 99) < p_ready, $urandom_range(0, 99) < p_rsp,
                      $urandom_range(0, 99) < p_idr, $urandom_range(0, 99) < p_red, rpc);
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
